// File: rtl/gsc_pkg.sv
// gsc_pkg: shared types and helpers for the gate sweep checker.
// Latency: n/a (types, constants and a pure function only).
// Backpressure: n/a.
package gsc_pkg;

  // Sequencer states for one sweep over the four input patterns.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    HOLD  = 2'd1,
    CHECK = 2'd2,
    FIN   = 2'd3
  } gsc_state_t;

  // Index of the last vector {a,b} = 2'b11 in the sweep.
  localparam logic [1:0] VEC_LAST = 2'd3;

  // Golden response of the gate under test.
  function automatic logic gsc_expect(input logic a, input logic b);
    return a & b;
  endfunction

endpackage

// File: rtl/gsc_hold_timer.sv
// gsc_hold_timer: loadable down-counter that times how long each vector is held.
// Latency: zero flag is valid the cycle after load; counts down one per enabled cycle.
// Backpressure: none; load takes priority over en, and the count stops at zero.
//
// Ports:
//   clk  - system clock, rising edge
//   rst  - synchronous active-high reset (count cleared)
//   load - reload the counter with HOLD_CYCLES-1
//   en   - decrement by one while above zero
//   zero - counter currently equals zero
module gsc_hold_timer
  import gsc_pkg::*;
#(
  parameter int HOLD_CYCLES = 2,
  localparam int CW = $clog2(HOLD_CYCLES) + 1
) (
  input  logic clk,
  input  logic rst,
  input  logic load,
  input  logic en,
  output logic zero
);

  localparam logic [CW-1:0] LOAD_VAL = CW'(HOLD_CYCLES - 1);

  logic [CW-1:0] cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= LOAD_VAL;
    end else if (en && (cnt != '0)) begin
      cnt <= cnt - CW'(1);
    end
  end

  assign zero = (cnt == '0);

endmodule

// File: rtl/gate_sweep_checker.sv
// gate_sweep_checker: drives a 2-input AND gate through 00,01,10,11 and checks its output.
// Latency: done pulses 1+4*(HOLD_CYCLES+1) cycles after start is accepted.
// Backpressure: start is only sampled in IDLE; starts during a sweep are dropped.
//
// Ports:
//   clk, rst          - clock (rising edge) and synchronous active-high reset
//   start             - begin a sweep (sampled only while idle)
//   a_o, b_o          - gate inputs driven to the device under test
//   c_i               - gate output returned by the device under test
//   busy              - high while a vector is being held or checked
//   done              - one-cycle pulse at the end of a sweep
//   pass, err_cnt     - result of the last sweep, held until the next start
//   fail_vec, fail_seen - first failing vector {a,b}; only with GSC_FIRST_FAIL_EN
//
// Build option: define GSC_FIRST_FAIL_EN to add first-failure capture.
module gate_sweep_checker
  import gsc_pkg::*;
#(
  parameter int HOLD_CYCLES = 2,
  parameter int ERR_W       = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  output logic             a_o,
  output logic             b_o,
  input  logic             c_i,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [ERR_W-1:0] err_cnt
`ifdef GSC_FIRST_FAIL_EN
  ,
  output logic [1:0]       fail_vec,
  output logic             fail_seen
`endif
);

  gsc_state_t state;
  logic [1:0] idx;
  logic       hold_zero;
  logic       tmr_load;
  logic       tmr_en;
  logic       mismatch;
  logic [ERR_W-1:0] err_next;
  logic [1:0] idx_next;

  // Reload on an accepted start and whenever CHECK hands over to the next vector.
  assign tmr_load = ((state == IDLE) && start) ||
                    ((state == CHECK) && (idx != VEC_LAST));
  assign tmr_en   = (state == HOLD);

  gsc_hold_timer #(
    .HOLD_CYCLES(HOLD_CYCLES)
  ) u_hold_timer (
    .clk (clk),
    .rst (rst),
    .load(tmr_load),
    .en  (tmr_en),
    .zero(hold_zero)
  );

  // a_o/b_o are registered, so the comparison is against the vector actually on the pins.
  assign mismatch = (c_i != gsc_expect(a_o, b_o));
  assign idx_next = idx + 2'd1;

  always_comb begin
    err_next = err_cnt;
    if (mismatch && (err_cnt != {ERR_W{1'b1}})) begin
      err_next = err_cnt + ERR_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      idx     <= 2'd0;
      a_o     <= 1'b0;
      b_o     <= 1'b0;
      busy    <= 1'b0;
      done    <= 1'b0;
      pass    <= 1'b0;
      err_cnt <= '0;
`ifdef GSC_FIRST_FAIL_EN
      fail_vec  <= 2'b00;
      fail_seen <= 1'b0;
`endif
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          a_o  <= 1'b0;
          b_o  <= 1'b0;
          busy <= 1'b0;
          if (start) begin
            state   <= HOLD;
            idx     <= 2'd0;
            busy    <= 1'b1;
            err_cnt <= '0;
            pass    <= 1'b0;
`ifdef GSC_FIRST_FAIL_EN
            fail_vec  <= 2'b00;
            fail_seen <= 1'b0;
`endif
          end
        end

        HOLD: begin
          if (hold_zero) begin
            state <= CHECK;
          end
        end

        CHECK: begin
          err_cnt <= err_next;
`ifdef GSC_FIRST_FAIL_EN
          if (mismatch && !fail_seen) begin
            fail_vec  <= {a_o, b_o};
            fail_seen <= 1'b1;
          end
`endif
          if (idx == VEC_LAST) begin
            // pass must reflect this final CHECK's update, so use err_next.
            state <= FIN;
            done  <= 1'b1;
            busy  <= 1'b0;
            a_o   <= 1'b0;
            b_o   <= 1'b0;
            pass  <= (err_next == '0);
          end else begin
            state <= HOLD;
            idx   <= idx_next;
            a_o   <= idx_next[1];
            b_o   <= idx_next[0];
          end
        end

        FIN: begin
          state <= IDLE;
        end

        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule
